// File: rtl/sp_regfile_gen.sv
// Parametrised single-port register file with post-reset clear sequencer, read-valid strobe and optional output register.
// Optional even-parity storage and error flag when SPRF_PARITY_EN is defined.
module sp_regfile_gen #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned READ_MODE  = 0,
  parameter int unsigned WRITE_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              par_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef SPRF_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [MEM_W-1:0]  mem_wd;

  logic [DATA_W-1:0] s0_q, s0_d;
  logic              v0_q, v0_d;
  logic              e0_q, e0_d;
  logic              acc;

  assign rd_word = mem_q[ad];
  assign rd_data = rd_word[DATA_W-1:0];

`ifdef SPRF_PARITY_EN
  // Stored bit makes the whole word XOR to zero, so any odd flip shows up.
  assign wr_word = {^din, din};
  assign rd_err  = ^rd_word;
`else
  assign wr_word = din;
  assign rd_err  = 1'b0;
`endif

  assign busy = (state_q == S_CLEAR);
  assign acc  = ce && !busy;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == {ADDR_W{1'b1}}) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = ad;
    mem_wd = wr_word;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_addr_q;
      mem_wd = '0;
    end else if (acc && wre) begin
      mem_we = 1'b1;
    end
  end

  // Array itself is not reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  always_comb begin
    s0_d = s0_q;
    v0_d = 1'b0;
    e0_d = e0_q;
    if (acc) begin
      if (!wre) begin
        s0_d = rd_data;
        v0_d = 1'b1;
        e0_d = rd_err;
      end else if (WRITE_MODE == 1) begin
        s0_d = din;
        v0_d = 1'b1;
        e0_d = 1'b0;
      end else if (WRITE_MODE == 2) begin
        s0_d = rd_data;
        v0_d = 1'b1;
        e0_d = rd_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= '0;
      v0_q <= 1'b0;
      e0_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      v0_q <= v0_d;
      e0_q <= e0_d;
    end
  end

  if (READ_MODE == 1) begin : g_pipe
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic              err_q;

    // A late oce still moves the held word out, but the strobe only marks fresh data.
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
      end else if (oce) begin
        dout_q <= s0_q;
        vld_q  <= v0_q;
        err_q  <= e0_q;
      end else begin
        vld_q  <= 1'b0;
      end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign par_err  = err_q;
  end else begin : g_bypass
    logic unused_oce;
    assign unused_oce = oce;
    assign dout       = s0_q;
    assign dout_vld   = v0_q;
    assign par_err    = e0_q;
  end

endmodule

// File: tb/tb_sp_regfile_gen.sv
// Scoreboard bench: four 8x4 instances (write modes 0/1/2, pipelined read) share stimulus; a 16x16 instance has its own.
module tb_sp_regfile_gen;

  logic clk;
  logic reset, ce, oce, wre;
  logic [1:0] ad;
  logic [7:0] din;
  logic [3:0][7:0] dout_a;
  logic [3:0] vld_a, busy_a, pe_a;

  logic rst_b, ce_b, wre_b;
  logic [3:0] ad_b;
  logic [15:0] din_b, dout_b;
  logic vld_b, busy_b, pe_b;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mdl  [4];
  logic [15:0] mdlb [16];
  logic [8:0]  q0[$], q1[$], q2[$], qr[$];
  logic [16:0] qb[$];

  sp_regfile_gen #(.WRITE_MODE(0)) u0 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout_a[0]), .dout_vld(vld_a[0]), .busy(busy_a[0]), .par_err(pe_a[0]));
  sp_regfile_gen #(.WRITE_MODE(1)) u1 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout_a[1]), .dout_vld(vld_a[1]), .busy(busy_a[1]), .par_err(pe_a[1]));
  sp_regfile_gen #(.WRITE_MODE(2)) u2 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout_a[2]), .dout_vld(vld_a[2]), .busy(busy_a[2]), .par_err(pe_a[2]));
  sp_regfile_gen #(.READ_MODE(1)) ur (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout_a[3]), .dout_vld(vld_a[3]), .busy(busy_a[3]), .par_err(pe_a[3]));
  sp_regfile_gen #(.DATA_W(16), .ADDR_W(4)) ub (.clk(clk), .reset(rst_b), .ce(ce_b), .oce(oce), .wre(wre_b),
    .ad(ad_b), .din(din_b), .dout(dout_b), .dout_vld(vld_b), .busy(busy_b), .par_err(pe_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    ce  = 1'b0;
    wre = 1'b0;
    repeat (n) step();
  endtask

  // pr: ur's output register will see oce=1 for this read; pe0: u0 expects a parity error
  task automatic acc(input logic w, input logic [1:0] a, input logic [7:0] d, input logic pr, input logic pe0);
    ce = 1'b1; wre = w; ad = a; din = d;
    if (!w) begin
      q0.push_back({pe0, mdl[a]});
      q1.push_back({1'b0, mdl[a]});
      q2.push_back({1'b0, mdl[a]});
      if (pr) qr.push_back({1'b0, mdl[a]});
    end else begin
      q1.push_back({1'b0, d});
      q2.push_back({1'b0, mdl[a]});
      mdl[a] = d;
    end
    step();
  endtask

  task automatic accb(input logic w, input logic [3:0] a, input logic [15:0] d);
    ce_b = 1'b1; wre_b = w; ad_b = a; din_b = d;
    if (!w) qb.push_back({1'b0, mdlb[a]});
    else    mdlb[a] = d;
    step();
    ce_b = 1'b0;
  endtask

  task automatic count_busy_a(input string tag);
    int cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_a == 4'hF) cnt++;
    end
    check(tag, cnt, 4);
    check({tag, "_done"}, busy_a, 4'h0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (vld_a[0]) begin
        if (q0.size() == 0) check("u0_spurious_vld", vld_a[0], 0);
        else check("u0_rd", {pe_a[0], dout_a[0]}, q0.pop_front());
      end
      if (vld_a[1]) begin
        if (q1.size() == 0) check("u1_spurious_vld", vld_a[1], 0);
        else check("u1_rd", {pe_a[1], dout_a[1]}, q1.pop_front());
      end
      if (vld_a[2]) begin
        if (q2.size() == 0) check("u2_spurious_vld", vld_a[2], 0);
        else check("u2_rd", {pe_a[2], dout_a[2]}, q2.pop_front());
      end
      if (vld_a[3]) begin
        if (qr.size() == 0) check("ur_spurious_vld", vld_a[3], 0);
        else check("ur_rd", {pe_a[3], dout_a[3]}, qr.pop_front());
      end
    end
    if (!rst_b && vld_b) begin
      if (qb.size() == 0) check("ub_spurious_vld", vld_b, 0);
      else check("ub_rd", {pe_b, dout_b}, qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; ce = 1'b0; oce = 1'b1; wre = 1'b0; ad = '0; din = '0;
    rst_b = 1'b1; ce_b = 1'b0; wre_b = 1'b0; ad_b = '0; din_b = '0;
    for (int i = 0; i < 4; i++)  mdl[i]  = '0;
    for (int i = 0; i < 16; i++) mdlb[i] = '0;

    repeat (3) step();
    check("rst_dout", dout_a, 32'h0);
    check("rst_vld", vld_a, 0);
    check("rst_perr", pe_a, 0);
    check("rst_busy", busy_a, 4'hF);
    check("rst_b_state", {busy_b, vld_b, pe_b, dout_b}, {3'b100, 16'h0});

    reset = 1'b0;
    count_busy_a("busy_cycles");
    step();

    for (int a = 0; a < 4; a++) acc(1'b0, 2'(a), 8'h00, 1'b1, 1'b0);
    nop(3);

    // write must leave the mode-0 output untouched
    acc(1'b1, 2'd2, 8'hA5, 1'b1, 1'b0);
    check("wm0_hold_on_write", {vld_a[0], dout_a[0]}, 9'h000);
    acc(1'b0, 2'd2, 8'h00, 1'b1, 1'b0);
    nop(3);

    acc(1'b1, 2'd1, 8'h11, 1'b1, 1'b0);
    acc(1'b1, 2'd1, 8'h22, 1'b1, 1'b0);
    acc(1'b0, 2'd1, 8'h00, 1'b1, 1'b0);
    nop(3);

    acc(1'b1, 2'd3, 8'h5C, 1'b1, 1'b0);
    nop(2);
    oce = 1'b0;
    acc(1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
    nop(2);
    check("oce_low_hold", dout_a[3], 8'h22);
    oce = 1'b1;
    step();
    check("oce_late_data", dout_a[3], 8'h5C);
    check("oce_late_vld", vld_a[3], 0);
    nop(2);

    acc(1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
    check("rm0_lat1", {vld_a[0], dout_a[0]}, 9'h15C);
    check("rm1_not_yet", vld_a[3], 0);
    nop(1);
    check("rm1_lat2", {vld_a[3], dout_a[3]}, 9'h15C);
    nop(3);

    for (int i = 0; i < 40; i++)
      acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    nop(4);

`ifdef SPRF_PARITY_EN
    acc(1'b1, 2'd0, 8'h0F, 1'b1, 1'b0);
    nop(2);
    u0.mem_q[0][8] = ~u0.mem_q[0][8];
    acc(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
    acc(1'b0, 2'd2, 8'h00, 1'b1, 1'b0);
    nop(4);
`endif

    check("q_empty_a", 32'(q0.size() + q1.size() + q2.size() + qr.size()), 0);

    // reset with a read in flight: nothing may emerge afterwards
    ce = 1'b1; wre = 1'b0; ad = 2'd2;
    step();
    reset = 1'b1; ce = 1'b0;
    step();
    check("rst_mid_dout", dout_a, 32'h0);
    check("rst_mid_vld", vld_a, 0);
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    reset = 1'b0;
    count_busy_a("busy_cycles_rerst");
    step();
    acc(1'b0, 2'd2, 8'h00, 1'b1, 1'b0);
    acc(1'b0, 2'd1, 8'h00, 1'b1, 1'b0);
    nop(4);

    rst_b = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_b) cnt++;
    end
    check("ub_busy_cycles", cnt, 16);
    step();
    for (int a = 0; a < 16; a++) accb(1'b1, 4'(a), 16'(a * 16'h1111 + 1));
    for (int a = 0; a < 16; a += 5) accb(1'b0, 4'(a), 16'h0);
    repeat (3) step();

    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    repeat (2) step();
    check("ub_busy_mid_clear", busy_b, 1);
    rst_b = 1'b1; ce_b = 1'b1; wre_b = 1'b1; ad_b = 4'd5; din_b = 16'hFFFF;
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 16; i++) mdlb[i] = '0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy_b) cnt++;
      else ce_b = 1'b0;
    end
    check("ub_busy_restart", cnt, 16);
    step();
    for (int a = 0; a < 16; a++) accb(1'b0, 4'(a), 16'h0);
    repeat (4) step();
    check("q_empty_b", 32'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
